// File: rtl/aes_share_loader_pkg.sv
// ============================================================================
// Module  : aes_share_loader_pkg
// Brief   : Shared sizing constants, helpers and FSM encoding for the
//           masked-AES share loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_share_loader_pkg;

  localparam int SL_D = 2;
  localparam int SL_W = 32;

  function automatic int kw_of(input int d, input int w);
    return (128 * d) / w;
  endfunction

  // Word index width; kept at least 1 bit so single-word vectors still elaborate.
  function automatic int idxw_of(input int kw);
    return (kw > 1) ? $clog2(kw) : 1;
  endfunction

  localparam int KW   = kw_of(SL_D, SL_W);
  localparam int NW   = 2 * KW;
  localparam int CNTW = $clog2(NW) + 1;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/aes_share_loader_if.sv
// ============================================================================
// Module  : aes_share_loader_if
// Brief   : Word-stream input, operand output and status bundle of the share
//           loader. Optional macro: AES_SHARE_LOADER_KEY_REUSE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_share_loader_if
  import aes_share_loader_pkg::*;
#(
  parameter int D = SL_D,
  parameter int W = SL_W
) ();

  logic [W-1:0]       in_data;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [128*D-1:0]   sh_key;
  logic [128*D-1:0]   sh_plaintext;
  logic               busy;
`ifdef AES_SHARE_LOADER_KEY_REUSE_EN
  logic               in_key_reuse;
`endif

  modport master (
    output in_data, in_valid, flush, out_ready,
`ifdef AES_SHARE_LOADER_KEY_REUSE_EN
    output in_key_reuse,
`endif
    input  in_ready, out_valid, sh_key, sh_plaintext, busy
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
`ifdef AES_SHARE_LOADER_KEY_REUSE_EN
    input  in_key_reuse,
`endif
    output in_ready, out_valid, sh_key, sh_plaintext, busy
  );

endinterface

`default_nettype wire

// File: rtl/aes_share_loader_share_word_buffer.sv
// ============================================================================
// Module  : share_word_buffer
// Brief   : 128*D-bit operand register written one W-bit word at a time.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module share_word_buffer #(
  parameter int D    = 2,
  parameter int W    = 32,
  parameter int IDXW = 3
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               i_we,
  input  wire logic [IDXW-1:0]    i_idx,
  input  wire logic [W-1:0]       i_word,
  output logic      [128*D-1:0]   o_data
);

  logic [128*D-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_we) begin
      r_data[int'(i_idx)*W +: W] <= i_word;
    end
  end

  assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/aes_share_loader.sv
// ============================================================================
// Module  : aes_share_loader
// Brief   : Deserialises key/plaintext share words into parallel operands and
//           offers them with valid/ready. Optional macro:
//           AES_SHARE_LOADER_KEY_REUSE_EN (skip the key half on reuse).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_share_loader
  import aes_share_loader_pkg::*;
#(
  parameter int D = SL_D,
  parameter int W = SL_W
) (
  input  wire logic           clk,
  input  wire logic           rst,
  aes_share_loader_if.slave   bus
);

  localparam int c_kw   = kw_of(D, W);
  localparam int c_nw   = 2 * c_kw;
  localparam int c_cntw = $clog2(c_nw) + 1;
  localparam int c_idxw = idxw_of(c_kw);

  localparam logic [c_cntw-1:0] c_last      = c_cntw'(c_nw - 1);
  localparam logic [c_cntw-1:0] c_kw_cnt    = c_cntw'(c_kw);
  localparam logic [c_cntw-1:0] c_reuse_cnt = c_cntw'(c_kw + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_cntw-1:0]   r_cnt;
  logic [c_cntw-1:0]   w_cnt_nxt;
  logic                r_key_loaded;
  logic                w_key_loaded_nxt;

  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_acc;
  logic                w_reuse;
  logic                w_key_half;
  logic                w_key_we;
  logic                w_pt_we;
  logic [c_idxw-1:0]   w_key_idx;
  logic [c_idxw-1:0]   w_pt_idx;

  // in_ready is forced low for the whole reset assertion, not just after it.
  assign w_in_ready  = (r_state == LOAD) & ~rst;
  assign w_out_valid = (r_state == FULL);
  assign w_acc       = bus.in_valid & w_in_ready & ~bus.flush;
  assign w_key_half  = (r_cnt < c_kw_cnt);

`ifdef AES_SHARE_LOADER_KEY_REUSE_EN
  assign w_reuse = w_acc & (r_cnt == '0) & bus.in_key_reuse & r_key_loaded;
`else
  assign w_reuse = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= LOAD;
      r_cnt        <= '0;
      r_key_loaded <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_key_loaded <= w_key_loaded_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_key_loaded_nxt = r_key_loaded;
    case (r_state)
      LOAD: begin
        if (bus.flush) begin
          w_cnt_nxt = '0;
        end else if (w_acc) begin
          if (w_reuse) begin
            // A reuse load is only the plaintext half; one-word halves finish here.
            if (c_kw == 1) begin
              w_cnt_nxt   = '0;
              w_state_nxt = FULL;
            end else begin
              w_cnt_nxt = c_reuse_cnt;
            end
          end else if (r_cnt == c_last) begin
            w_cnt_nxt        = '0;
            w_key_loaded_nxt = 1'b1;
            w_state_nxt      = FULL;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          w_state_nxt = LOAD;
        end
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

  assign w_key_we  = w_acc & w_key_half & ~w_reuse;
  assign w_pt_we   = w_acc & (~w_key_half | w_reuse);
  assign w_key_idx = r_cnt[c_idxw-1:0];
  assign w_pt_idx  = w_reuse ? '0 : c_idxw'(r_cnt - c_kw_cnt);

  share_word_buffer #(
    .D    (D),
    .W    (W),
    .IDXW (c_idxw)
  ) u_key_buf (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_key_we),
    .i_idx  (w_key_idx),
    .i_word (bus.in_data),
    .o_data (bus.sh_key)
  );

  share_word_buffer #(
    .D    (D),
    .W    (W),
    .IDXW (c_idxw)
  ) u_pt_buf (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_pt_we),
    .i_idx  (w_pt_idx),
    .i_word (bus.in_data),
    .o_data (bus.sh_plaintext)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = (r_cnt != '0) | w_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_aes_share_loader.sv
// ============================================================================
// Module  : tb_aes_share_loader
// Brief   : Directed self-checking bench for aes_share_loader (D=2, W=32).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_share_loader;

  localparam int KW = 8;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  aes_share_loader_if #(.D(2), .W(32)) bus ();

  aes_share_loader #(.D(2), .W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [255:0] m_key;
  logic [255:0] m_pt;
  int           m_cnt;
  logic         m_key_loaded;
  logic [511:0] sb_q[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_key        = '0;
    m_pt         = '0;
    m_cnt        = 0;
    m_key_loaded = 1'b0;
    sb_q.delete();
  endtask

  // Present one word and hold it until accepted; model updated on acceptance.
  task automatic send_word(input logic [31:0] w, input logic reuse);
    logic acc;
    acc = 1'b0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
`ifdef AES_SHARE_LOADER_KEY_REUSE_EN
    bus.in_key_reuse = reuse;
`endif
    for (int k = 0; k < 50; k++) begin
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      chk("accept_timeout", 512'd0, 512'd1);
    end else begin
      if (m_cnt == 0 && reuse && m_key_loaded) begin
        m_pt[31:0] = w;
        m_cnt = KW + 1;
      end else begin
        if (m_cnt < KW) m_key[m_cnt*32 +: 32] = w;
        else            m_pt[(m_cnt-KW)*32 +: 32] = w;
        m_cnt++;
      end
      if (m_cnt == NW) begin
        m_cnt = 0;
        m_key_loaded = 1'b1;
        sb_q.push_back({m_key, m_pt});
      end
    end
`ifdef AES_SHARE_LOADER_KEY_REUSE_EN
    bus.in_key_reuse = 1'b0;
`endif
  endtask

  task automatic sb_check(input string tag);
    logic [511:0] e;
    total++;
    assert (sb_q.size() != 0) else begin
      bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk(tag, {bus.sh_key, bus.sh_plaintext}, e);
    end
  endtask

  task automatic take_output(input string tag);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk(tag, {511'd0, bus.out_valid}, 512'd0);
  endtask

  logic [255:0] saved_key;

  initial begin
    rst           = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
`ifdef AES_SHARE_LOADER_KEY_REUSE_EN
    bus.in_key_reuse = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {511'd0, bus.out_valid}, 512'd0);
    chk("rst_in_ready",  {511'd0, bus.in_ready},  512'd0);
    chk("rst_busy",      {511'd0, bus.busy},      512'd0);
    chk("rst_key",       {256'd0, bus.sh_key},       512'd0);
    chk("rst_pt",        {256'd0, bus.sh_plaintext}, 512'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {511'd0, bus.in_ready}, 512'd1);

    // Basic 16-word load
    for (int i = 0; i < NW; i++) begin
      if (i == NW - 1) chk("pre_last_out_valid", {511'd0, bus.out_valid}, 512'd0);
      send_word(32'(i), 1'b0);
    end
    chk("load1_out_valid", {511'd0, bus.out_valid}, 512'd1);
    chk("load1_busy",      {511'd0, bus.busy},      512'd1);
    chk("load1_key_lo",    {480'd0, bus.sh_key[31:0]},          512'h0);
    chk("load1_key_hi",    {480'd0, bus.sh_key[255:224]},       512'h7);
    chk("load1_pt_lo",     {480'd0, bus.sh_plaintext[31:0]},    512'h8);
    chk("load1_pt_hi",     {480'd0, bus.sh_plaintext[255:224]}, 512'hF);
    sb_check("load1_vectors");

    // Backpressure from the core while upstream keeps offering a word
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEADBEEF;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("hold_in_ready",  {511'd0, bus.in_ready},  512'd0);
      chk("hold_out_valid", {511'd0, bus.out_valid}, 512'd1);
    end
    chk("hold_key", {256'd0, bus.sh_key},       {256'd0, m_key});
    chk("hold_pt",  {256'd0, bus.sh_plaintext}, {256'd0, m_pt});
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("hs_cycle_in_ready", {511'd0, bus.in_ready}, 512'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("after_hs_in_ready",  {511'd0, bus.in_ready},  512'd1);
    chk("after_hs_out_valid", {511'd0, bus.out_valid}, 512'd0);
    chk("after_hs_key_kept",  {256'd0, bus.sh_key},    {256'd0, m_key});

    // Flush after a partial load, word presented during flush is dropped
    for (int i = 0; i < 5; i++) send_word(32'h100 + 32'(i), 1'b0);
    chk("partial_busy", {511'd0, bus.busy}, 512'd1);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h00000BAD;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    m_cnt = 0;
    chk("flush_busy", {511'd0, bus.busy}, 512'd0);
    for (int i = 0; i < NW; i++) send_word(32'hA5A5A5A5, 1'b0);
    chk("flush_load_out_valid", {511'd0, bus.out_valid}, 512'd1);
    chk("flush_load_key", {256'd0, bus.sh_key},       {256'd0, {8{32'hA5A5A5A5}}});
    chk("flush_load_pt",  {256'd0, bus.sh_plaintext}, {256'd0, {8{32'hA5A5A5A5}}});
    sb_check("flush_load_vectors");
    take_output("flush_load_release");

    // Asynchronous reset in the middle of a load
    for (int i = 0; i < 10; i++) send_word(32'h200 + 32'(i), 1'b0);
    bus.in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {511'd0, bus.out_valid}, 512'd0);
    chk("midrst_in_ready",  {511'd0, bus.in_ready},  512'd0);
    chk("midrst_busy",      {511'd0, bus.busy},      512'd0);
    chk("midrst_key",       {256'd0, bus.sh_key},       512'd0);
    chk("midrst_pt",        {256'd0, bus.sh_plaintext}, 512'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < NW; i++) send_word($urandom, 1'b0);
    chk("postrst_out_valid", {511'd0, bus.out_valid}, 512'd1);
    sb_check("postrst_vectors");
    take_output("postrst_release");

    // Gapped input stream
    for (int i = 0; i < NW; i++) begin
      send_word(32'h300 + 32'(i), 1'b0);
      bus.in_valid = 1'b0;
      if (i < NW - 1) chk("gap_out_valid_low", {511'd0, bus.out_valid}, 512'd0);
      else            chk("gap_out_valid_high", {511'd0, bus.out_valid}, 512'd1);
      if (i < NW - 1) begin
        @(posedge clk);
        #1;
      end
    end
    sb_check("gap_vectors");
    take_output("gap_release");

`ifdef AES_SHARE_LOADER_KEY_REUSE_EN
    saved_key = m_key;
    for (int i = 0; i < KW; i++) begin
      send_word(32'h11 + 32'(i), (i == 0));
      if (i < KW - 1) chk("reuse_out_valid_low", {511'd0, bus.out_valid}, 512'd0);
    end
    chk("reuse_out_valid", {511'd0, bus.out_valid}, 512'd1);
    chk("reuse_key_same",  {256'd0, bus.sh_key}, {256'd0, saved_key});
    chk("reuse_pt_lo",     {480'd0, bus.sh_plaintext[31:0]}, 512'h11);
    sb_check("reuse_vectors");
    take_output("reuse_release");

    #1;
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < NW; i++) begin
      send_word(32'h400 + 32'(i), (i == 0));
      if (i == KW - 1) chk("reuse_after_rst_not_short", {511'd0, bus.out_valid}, 512'd0);
    end
    chk("reuse_after_rst_full", {511'd0, bus.out_valid}, 512'd1);
    sb_check("reuse_after_rst_vectors");
    take_output("reuse_after_rst_release");
`else
    saved_key = '0;
`endif

    chk("scoreboard_drained", 512'(sb_q.size()), 512'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/aes_share_loader.md
Name: aes_share_loader

Overview:
- Upstream neighbour of the masked AES-128 core. Deserialises a narrow word stream carrying key shares and plaintext shares into the full 128*d-bit sh_key / sh_plaintext vectors.
- Presents the assembled vectors to the core with a valid/ready handshake, so the core sees its parallel operands only when a complete set has been loaded.
- Word order is fixed: all key-share words first, then all plaintext-share words, each group LSB-word first.

Parameters:
- d, 2, number of shares per bit (must match the core).
- W, 32, input word width; 128*d must be a multiple of W.
- KW (localparam), 128*d/W, words per share vector; total words per load NW = 2*KW.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- in_data  input  W  share word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- flush  input  1  synchronous abort of a partial load.
- out_valid  output  1  sh_key/sh_plaintext complete; drives core valid_in.
- out_ready  input  1  core ready.
- sh_key  output  128*d  assembled key shares (register outputs).
- sh_plaintext  output  128*d  assembled plaintext shares (register outputs).
- busy  output  1  load in progress (cnt != 0 or out_valid).

Behaviour:
- Reset (async, rst=1):
  - State LOAD, cnt=0, key_loaded=0.
  - All buffer bits 0, so sh_key and sh_plaintext read 0.
  - out_valid=0, in_ready=0 while rst is high; busy=0.
- States:
  - LOAD: in_ready=1, out_valid=0.
  - FULL: in_ready=0, out_valid=1.
- Word handshake (in_valid & in_ready):
  - If cnt<KW, in_data is written to sh_key[cnt*W +: W]; otherwise to sh_plaintext[(cnt-KW)*W +: W].
  - cnt increments by 1.
  - On the handshake with cnt==NW-1: cnt wraps to 0, key_loaded is set, state goes to FULL.
  - The full operand set is therefore visible one cycle after the last word.
- Output handshake: in FULL, out_valid & out_ready moves the state to LOAD next cycle. in_ready is 0 in the handshake cycle and 1 from the next cycle.
  - Minimum load-to-load period: NW + 1 cycles.
- Stability:
  - sh_key/sh_plaintext are never written while out_valid=1.
  - After the output handshake the buffers keep their values until overwritten word by word.
  - The core must sample them at the handshake.
- out_valid, once high, stays high until out_ready; it is not withdrawn.
- flush:
  - In LOAD: cnt goes to 0 next cycle. Any word presented in the same cycle is dropped (flush has priority). Buffers are not cleared.
  - In FULL: ignored, since the handshake has already been offered.
- in_valid while in FULL: not accepted; the upstream must hold the word.
- cnt width: $clog2(NW)+1 bits; no overflow, because the wrap happens at NW-1.
- Reset mid-load or in FULL: everything returns to reset values immediately; the partial load is lost.

Optional Feature:
- Macro: AES_SHARE_LOADER_KEY_REUSE_EN.
- With the macro:
  - Extra input port in_key_reuse (1 bit), sampled only on a word handshake with cnt==0.
  - If in_key_reuse=1 and key_loaded=1, that word is written to sh_plaintext[0 +: W] and cnt jumps to KW+1. The load then finishes after KW words and sh_key is untouched.
  - If key_loaded=0, in_key_reuse is ignored and a full NW-word load occurs.
- Without the macro: the port is absent and every load is NW words.

Decomposition:
- Shared package holds:
  - localparams KW, NW, CNTW;
  - the state encoding (LOAD=1'b0, FULL=1'b1).
- One natural sub-module: share_word_buffer. It is a 128*d-bit register with write-enable, W-bit word index and word input, instantiated twice (key and plaintext).
- The FSM and counter live in the top.

Test Plan:
- Reset then 16 words 0x00000000..0x0000000F (d=2, W=32):
  - out_valid rises exactly 1 cycle after word 15;
  - sh_key[31:0]=0x0, sh_key[255:224]=0x7;
  - sh_plaintext[31:0]=0x8, sh_plaintext[255:224]=0xF.
- Hold out_ready=0 for 10 cycles after FULL while in_valid=1: in_ready stays 0, buffers unchanged, out_valid stays 1. Raise out_ready: in_ready=1 the next cycle.
- flush after 5 words, then a new 16-word load of 0xA5A5A5A5: all of sh_key and sh_plaintext read 0xA5A5A5A5 repeated; the old partial words are gone.
- Assert rst mid-load (after word 9): all outputs go 0 immediately. The next 16-word load completes normally.
- in_valid toggled every other cycle: out_valid appears after exactly 16 accepted words.
- (KEY_REUSE_EN) Full load, then in_key_reuse=1 with 8 words 0x11..0x18: out_valid after 8 words, sh_key unchanged, sh_plaintext[31:0]=0x11. Reuse requested straight after reset forces a 16-word load.
